// File: rtl/vector_scalar_reduce.sv
// Reduces each traced N-lane vector to a scalar (sum or max) or passes it through,
// using a registered binary tree with one input stage and one stage per tree level.
module vector_scalar_reduce #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int DATA_TYPE          = 0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0,
    localparam int CHAIN_W           = $clog2(MAX_CHAINS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tracing,
    input  logic                    valid_in,
    input  logic [1:0]              eof_in,
    input  logic [1:0]              bof_in,
    input  logic [CHAIN_W-1:0]      chainId_in,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic                    valid_out,
    output logic [1:0]              eof_out,
    output logic [1:0]              bof_out,
    output logic [CHAIN_W-1:0]      chainId_out
);

    localparam int LEVELS = $clog2(N);
    localparam logic [7:0] CFG_ID = 8'(PERSONAL_CONFIG_ID);
    localparam logic [8:0] CHAIN_LIMIT = 9'(MAX_CHAINS);

    typedef enum logic [1:0] {OP_PASS = 2'd0, OP_SUM = 2'd1, OP_MAX = 2'd2} op_t;

    logic [7:0]            firmware_op [MAX_CHAINS];
    logic [7:0]            byte_counter;

    logic [DATA_WIDTH-1:0] lane_q  [LEVELS+1][N];
    op_t                   op_q    [LEVELS+1];
    logic                  valid_q [LEVELS+1];
    logic [1:0]            eof_q   [LEVELS+1];
    logic [1:0]            bof_q   [LEVELS+1];
    logic [CHAIN_W-1:0]    chain_q [LEVELS+1];

    op_t                   op_lookup;

    // Lane a is always the lower index, so ">=" makes it win ties.
    function automatic logic [DATA_WIDTH-1:0] combine(input op_t op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic a_wins;
        if (DATA_TYPE == 1) a_wins = ($signed(a) >= $signed(b));
        else                a_wins = (a >= b);
        if (op == OP_SUM) return a + b;
        else              return a_wins ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < MAX_CHAINS; c++) firmware_op[c] <= INITIAL_FIRMWARE_OP[c*8 +: 8];
            byte_counter <= '0;
        end else if (!tracing) begin
            if (configId == CFG_ID) begin
                if ({1'b0, byte_counter} < CHAIN_LIMIT)
                    firmware_op[byte_counter[CHAIN_W-1:0]] <= configData;
                if (byte_counter != 8'hFF) byte_counter <= byte_counter + 8'd1;
            end else begin
                byte_counter <= '0;
            end
        end
    end

    always_comb begin
        op_lookup = OP_PASS;
        case (firmware_op[chainId_in])
            8'd1:    op_lookup = OP_SUM;
            8'd2:    op_lookup = OP_MAX;
            default: op_lookup = OP_PASS;
        endcase
    end

    // Data, op and side-band stages shift every cycle; only the input valid depends on tracing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LEVELS; k++) begin
                valid_q[k] <= 1'b0;
                op_q[k]    <= OP_PASS;
                eof_q[k]   <= '0;
                bof_q[k]   <= '0;
                chain_q[k] <= '0;
                for (int i = 0; i < N; i++) lane_q[k][i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_in & tracing;
            op_q[0]    <= op_lookup;
            eof_q[0]   <= eof_in;
            bof_q[0]   <= bof_in;
            chain_q[0] <= chainId_in;
            for (int i = 0; i < N; i++) lane_q[0][i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];

            for (int k = 1; k <= LEVELS; k++) begin
                valid_q[k] <= valid_q[k-1];
                op_q[k]    <= op_q[k-1];
                eof_q[k]   <= eof_q[k-1];
                bof_q[k]   <= bof_q[k-1];
                chain_q[k] <= chain_q[k-1];
                for (int i = 0; i < N; i++)
                    lane_q[k][i] <= (op_q[k-1] == OP_PASS) ? lane_q[k-1][i] : '0;
                // Level k keeps N>>k partial results in the low lanes.
                for (int i = 0; i < N/2; i++)
                    if (op_q[k-1] != OP_PASS && i < (N >> k))
                        lane_q[k][i] <= combine(op_q[k-1], lane_q[k-1][2*i], lane_q[k-1][2*i+1]);
            end
        end
    end

    always_comb begin
        vector_out = '0;
        for (int i = 0; i < N; i++) vector_out[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[LEVELS][i];
    end

    assign valid_out   = valid_q[LEVELS] & tracing;
    assign eof_out     = eof_q[LEVELS];
    assign bof_out     = bof_q[LEVELS];
    assign chainId_out = chain_q[LEVELS];

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Bench for vector_scalar_reduce: an unsigned and a signed instance share one stimulus
// stream; each output is matched against a queue of hand-computed results.
module tb_vector_scalar_reduce;

    localparam int EXP_W = 16 + 2 + 2 + 2 + 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tracing = 1'b1;
    logic         valid_in = 1'b0;
    logic [1:0]   eof_in = '0;
    logic [1:0]   bof_in = '0;
    logic [1:0]   chainId_in = '0;
    logic [7:0]   configId = 8'hFF;
    logic [7:0]   configData = '0;
    logic [255:0] vector_in = '0;

    logic [255:0] vector_out_u, vector_out_s;
    logic         valid_out_u, valid_out_s;
    logic [1:0]   eof_out_u, eof_out_s, bof_out_u, bof_out_s;
    logic [1:0]   chainId_out_u, chainId_out_s;

    logic [15:0]      cyc = '0;
    logic [31:0]      lanes [8];
    logic [7:0]       cfg [8];
    logic [EXP_W-1:0] exp_u[$];
    logic [EXP_W-1:0] exp_s[$];
    int               checks = 0;
    int               failures = 0;

    vector_scalar_reduce #(.DATA_TYPE(0)) u_dut (
        .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .vector_out(vector_out_u), .valid_out(valid_out_u), .eof_out(eof_out_u),
        .bof_out(bof_out_u), .chainId_out(chainId_out_u)
    );

    vector_scalar_reduce #(.DATA_TYPE(1)) s_dut (
        .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .vector_out(vector_out_s), .valid_out(valid_out_s), .eof_out(eof_out_s),
        .bof_out(bof_out_s), .chainId_out(chainId_out_s)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // Monitor: sample on the falling edge and pop one expected result per valid output
    initial begin
        logic [EXP_W-1:0] act, e;
        forever begin
            @(negedge clk);
            if (valid_out_u) begin
                checks++;
                act = {cyc, chainId_out_u, bof_out_u, eof_out_u, vector_out_u};
                if (exp_u.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unsigned unexpected output act=%h", act);
                end else begin
                    e = exp_u.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL sb_unsigned act=%h exp=%h", act, e);
                    end
                end
            end
            if (valid_out_s) begin
                checks++;
                act = {cyc, chainId_out_s, bof_out_s, eof_out_s, vector_out_s};
                if (exp_s.size() == 0) begin
                    failures++;
                    $display("FAIL sb_signed unexpected output act=%h", act);
                end else begin
                    e = exp_s.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL sb_signed act=%h exp=%h", act, e);
                    end
                end
            end
        end
    end

    // Drivers
    task automatic issue(input logic [1:0] ch, input logic [1:0] ef, input logic [1:0] bf,
                         input bit reduce, input logic [31:0] ru, input logic [31:0] rs,
                         input bit keep);
        logic [255:0] pv;
        for (int i = 0; i < 8; i++) pv[i*32 +: 32] = lanes[i];
        @(posedge clk); #1;
        valid_in = 1'b1; vector_in = pv; chainId_in = ch; eof_in = ef; bof_in = bf;
        if (keep) begin
            exp_u.push_back({cyc + 16'd4, ch, bf, ef, reduce ? {224'd0, ru} : pv});
            exp_s.push_back({cyc + 16'd4, ch, bf, ef, reduce ? {224'd0, rs} : pv});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic configure(input int nb);
        @(posedge clk); #1;
        valid_in = 1'b0; tracing = 1'b0; configId = 8'hFF;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            configId = 8'h00; configData = cfg[i];
        end
        @(posedge clk); #1;
        configId = 8'hFF; tracing = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({valid_out_u, chainId_out_u, bof_out_u, eof_out_u, vector_out_u} !== '0) begin
            failures++;
            $display("FAIL %s_unsigned act valid=%b ch=%h bof=%h eof=%h vec=%h exp all zero",
                     tag, valid_out_u, chainId_out_u, bof_out_u, eof_out_u, vector_out_u);
        end
        checks++;
        if ({valid_out_s, chainId_out_s, bof_out_s, eof_out_s, vector_out_s} !== '0) begin
            failures++;
            $display("FAIL %s_signed act valid=%b ch=%h bof=%h eof=%h vec=%h exp all zero",
                     tag, valid_out_s, chainId_out_s, bof_out_s, eof_out_s, vector_out_s);
        end
    endtask

    initial begin
        // Reset
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_zero("reset_init");

        // Chain 0 = sum, chain 1 = max, chains 2/3 = passthrough
        cfg = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        configure(4);
        lanes = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        issue(2'd0, 2'd1, 2'd0, 1'b1, 32'd36, 32'd36, 1'b1);
        lanes = '{8{32'h4000_0000}};
        issue(2'd0, 2'd0, 2'd2, 1'b1, 32'h0, 32'h0, 1'b1);
        lanes = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        issue(2'd1, 2'd2, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        lanes = '{32'h8000_0000, 32'd7, 32'hFFFF_FFFE, 32'h12, 32'd0, 32'd3, 32'h9000_0000, 32'd1};
        issue(2'd1, 2'd3, 2'd3, 1'b1, 32'hFFFF_FFFE, 32'h12, 1'b1);
        lanes = '{32'd3, 32'd9, 32'd9, 32'd2, 32'd7, 32'd1, 32'd0, 32'd8};
        issue(2'd1, 2'd0, 2'd1, 1'b1, 32'd9, 32'd9, 1'b1);
        lanes = '{32'hDEAD_BEEF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'hCAFE_F00D};
        issue(2'd2, 2'd1, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(6);

        // Reprogram: {2,1,0,3}, trailing bytes ignored
        cfg = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd9, 8'd9, 8'd0, 8'd0};
        configure(6);
        lanes = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd5};
        issue(2'd0, 2'd1, 2'd2, 1'b1, 32'd70, 32'd70, 1'b1);
        lanes = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        issue(2'd1, 2'd2, 2'd1, 1'b1, 32'd27, 32'd27, 1'b1);
        lanes = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 32'd66, 32'd77, 32'd88};
        issue(2'd2, 2'd3, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        lanes = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1004, 32'h1005, 32'h1006, 32'h1007};
        issue(2'd3, 2'd0, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(6);

        // Tracing drop: first two vectors emerge while tracing=0, the third survives
        lanes = '{8{32'd1}};
        issue(2'd1, 2'd1, 2'd0, 1'b1, 32'd8, 32'd8, 1'b0);
        lanes = '{8{32'd2}};
        issue(2'd1, 2'd2, 2'd0, 1'b1, 32'd16, 32'd16, 1'b0);
        lanes = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100};
        issue(2'd1, 2'd3, 2'd2, 1'b1, 32'd100, 32'd100, 1'b1);
        idle(1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tracing = 1'b0; valid_in = 1'b1; vector_in = {8{32'h7777_0000}}; chainId_in = 2'd1;
        end
        @(posedge clk); #1;
        tracing = 1'b1; valid_in = 1'b0;
        lanes = '{8{32'd5}};
        issue(2'd1, 2'd0, 2'd0, 1'b1, 32'd40, 32'd40, 1'b1);
        idle(6);

        // Reset with three vectors in flight; firmware returns to all-passthrough
        lanes = '{8{32'd3}};
        issue(2'd0, 2'd1, 2'd1, 1'b1, 32'd3, 32'd3, 1'b0);
        issue(2'd1, 2'd2, 2'd2, 1'b1, 32'd24, 32'd24, 1'b0);
        issue(2'd0, 2'd3, 2'd3, 1'b1, 32'd3, 32'd3, 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("reset_mid");
        lanes = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        issue(2'd0, 2'd2, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
        lanes = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        issue(2'd1, 2'd1, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(8);

        // Final report
        checks++;
        if (exp_u.size() != 0) begin
            failures++;
            $display("FAIL drain_unsigned act pending=%0d exp 0", exp_u.size());
        end
        checks++;
        if (exp_s.size() != 0) begin
            failures++;
            $display("FAIL drain_signed act pending=%0d exp 0", exp_s.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_scalar_reduce.md
# vector_scalar_reduce

Reduces each traced N-element vector to one scalar (sum or max) or passes it through unchanged, selected per chain by firmware. It sits directly downstream of the vector-vector ALU stage and consumes its vector, valid, eof, bof and chainId outputs. Its results feed the data packer. The reduction is a fully pipelined, registered binary tree that accepts one vector per cycle with no backpressure.

## Interface
- N, 8, vector lanes; power of two, ≥1
- DATA_WIDTH, 32, bits per element
- MAX_CHAINS, 4, number of firmware chains; power of two, ≥2
- PERSONAL_CONFIG_ID, 0, configId value that targets this block
- DATA_TYPE, 0, 0 = unsigned integer; 1 = signed fixed point (two's complement)
- INITIAL_FIRMWARE_OP, all 0, [7:0] per chain; op loaded at reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- tracing  in  1  1 = process stream; 0 = configuration mode
- valid_in  in  1  input vector valid
- eof_in  in  2  end-of-frame flags, carried with data
- bof_in  in  2  begin-of-frame flags, carried with data
- chainId_in  in  clog2(MAX_CHAINS)  chain selecting the firmware op
- configId  in  8  configuration target id
- configData  in  8  configuration byte
- vector_in  in  N×DATA_WIDTH  input lanes
- vector_out  out  N×DATA_WIDTH  result lanes
- valid_out  out  1  result valid
- eof_out  out  2  delayed eof_in
- bof_out  out  2  delayed bof_in
- chainId_out  out  clog2(MAX_CHAINS)  delayed chainId_in

## Operation
- firmware_op[c] selects the op for chain c:
  - 0 = passthrough
  - 1 = sum
  - 2 = max
  - Values ≥3 behave as passthrough.
- The op is looked up with chainId_in in the input stage and travels with the data through the pipeline.
- Sum: wraps modulo 2^DATA_WIDTH. Every tree node is DATA_WIDTH bits and carries are discarded.
- Max:
  - DATA_TYPE=0 uses an unsigned compare.
  - DATA_TYPE=1 uses a signed compare.
  - On a tie, the lower-index lane wins. The values are identical, but this fixes the mux select for equivalence checking.
- Reduce output: vector_out[0] = scalar result, and lanes 1..N-1 = 0.
- Passthrough output: vector_out = vector_in, delayed to the same latency as a reduce.
- eof, bof and chainId are delayed alongside the data, unmodified, for every op.
- Configuration, active while tracing=0 and configId==PERSONAL_CONFIG_ID:
  - An 8-bit byte_counter increments once per cycle.
  - While byte_counter < MAX_CHAINS, firmware_op[byte_counter] ← configData.
  - Bytes arriving at byte_counter ≥ MAX_CHAINS are ignored. The counter saturates at 255.
  - When configId ≠ PERSONAL_CONFIG_ID, byte_counter ← 0.
  - While tracing=1, the counter holds its value and no firmware write occurs.
- Mode rules:
  - Stage valids capture valid_in & tracing, so input is ignored while tracing=0.
  - valid_out is forced to 0 in any cycle with tracing=0, and in-flight vectors emerging during that cycle are dropped.
  - The data, eof, bof and chainId pipelines keep shifting regardless of tracing.

## Timing
- Latency L = clog2(N)+1 cycles from valid_in to valid_out.
  - One input register, then one register per tree level.
  - N=8 gives L=4; N=1 gives L=1.
- Throughput: one vector per cycle, back-to-back, with different chains and ops allowed in consecutive cycles.
- A firmware write in cycle t affects vectors entering at t+1 or later.
- Reset, in the cycle rst=1:
  - All stage valids ← 0, and valid_out ← 0.
  - vector_out, eof_out, bof_out and chainId_out ← 0.
  - firmware_op ← INITIAL_FIRMWARE_OP, and byte_counter ← 0.
- Reset mid-stream: in-flight vectors are discarded. The first valid_out can occur L cycles after the first post-reset valid_in.
- Reset mid-configuration: partial writes are undone, because the firmware returns to its initial values.
- rst has priority over tracing and configuration.

## Test plan
- Sum with N=8, DATA_TYPE=0, chain 0 op=1: vector_in = {1..8} at cycle t → at t+4, valid_out=1 and vector_out = {36,0,0,0,0,0,0,0}.
- Max and signedness: lanes {0xFFFFFFFF, 5, 0, …, 0}, op=2.
  - DATA_TYPE=1 → lane0 = 5.
  - DATA_TYPE=0 → lane0 = 0xFFFFFFFF.
- Wrap: eight lanes of 0x40000000, op=1 → lane0 = 0x00000000.
- Config then stream:
  - Configuration: tracing=0 and configId=PERSONAL_CONFIG_ID for 6 cycles with bytes 2,1,0,3,9,9. Expect firmware = {2,1,0,3}, with the extra bytes ignored.
  - Stream: back-to-back vectors on chains 0,1,2,3 → max, sum, passthrough, passthrough on 4 consecutive output cycles.
  - Check: eof, bof and chainId match their inputs.
- Tracing drop: 3 valid vectors, then tracing=0 for 2 cycles mid-flight → no valid_out in those 2 cycles. Vectors emerging during them are lost, and later vectors are unaffected.
- Reset:
  - Assert rst while 3 vectors are in flight → no valid_out from them.
  - After reset, firmware is back to INITIAL_FIRMWARE_OP.
  - All outputs read 0 one cycle after rst.
